// File: rtl/fir_pkg.sv
// Shared types and constants for the I/Q sample path.
// Samp carries one complex sample as two signed 1.23 values, I in the upper half.
package fir_pkg;

   localparam int NUM_TAPS = 29;
   localparam int NUM_COEF = 15;

   typedef struct packed {
      logic signed [23:0] I;
      logic signed [23:0] Q;
   } Samp;

   typedef struct packed {
      logic signed [26:0] I;
      logic signed [26:0] Q;
   } Coef;

   // Full-precision product of a Samp component with a Coef component (24 + 27 bits)
   typedef struct packed {
      logic signed [50:0] I;
      logic signed [50:0] Q;
   } Partial_product;

endpackage

// File: rtl/fifo_mem.sv
// Sample storage for the fifo: DEPTH entries, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module fifo_mem
   import fir_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  Samp           wr_data,
   input  logic [AW-1:0] rd_addr,
   output Samp           rd_data
);

   Samp mem [DEPTH];

   // Write the incoming sample on the rising edge when the push was accepted
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo.sv
// First-word-fall-through FIFO of I/Q samples.
// Pointers carry one extra wrap bit so full and empty are told apart without
// a counter. Optional sticky error output enabled by macro FIFO_ERR_EN.
module fifo
   import fir_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        PushIn,
   input  logic [23:0] SampI,
   input  logic [23:0] SampQ,
   input  logic        fifo_PullOut,
   output Samp         fifo_samp,
   output logic        fifo_full,
   output logic        fifo_empty
`ifdef FIFO_ERR_EN
   ,
   output logic        fifo_err
`endif
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pull_ok;
   Samp              wr_data;
   Samp              rd_data;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

   // A pull frees a slot in the same cycle, so a full FIFO may still accept a push alongside it
   assign pull_ok = fifo_PullOut && !fifo_empty;
   assign push_ok = PushIn && (!fifo_full || pull_ok);

   assign wr_data.I = SampI;
   assign wr_data.Q = SampQ;

   // Output zeros when empty; there is no bypass from the write port
   assign fifo_samp = fifo_empty ? '0 : rd_data;

   fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (Clk),
      .wr_en   (push_ok),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data (wr_data),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (rd_data)
   );

   // Advance the pointers on accepted transfers; reset drops every held entry
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pull_ok) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

`ifdef FIFO_ERR_EN
   logic push_drop;
   logic pull_ignore;

   assign push_drop   = PushIn && !push_ok;
   assign pull_ignore = fifo_PullOut && fifo_empty;

   // Remember any dropped push or ignored pull until the next reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         fifo_err <= 1'b0;
      end else if (push_drop || pull_ignore) begin
         fifo_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo. A queue models the FIFO contents: accepted
// pushes are appended, and every pull compares the DUT head with the front.
// Checks fifo_err too when built with FIFO_ERR_EN.
module tb_fifo;
   import fir_pkg::*;

   localparam int DEPTH = 8;

   logic        Clk;
   logic        Reset;
   logic        PushIn;
   logic [23:0] SampI;
   logic [23:0] SampQ;
   logic        fifo_PullOut;
   Samp         fifo_samp;
   logic        fifo_full;
   logic        fifo_empty;
`ifdef FIFO_ERR_EN
   logic        fifo_err;
`endif

   Samp  sb [$];
   int   checks;
   int   errors;
   logic err_exp;

   fifo #(.DEPTH(DEPTH)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .PushIn       (PushIn),
      .SampI        (SampI),
      .SampQ        (SampQ),
      .fifo_PullOut (fifo_PullOut),
      .fifo_samp    (fifo_samp),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty)
`ifdef FIFO_ERR_EN
      ,
      .fifo_err     (fifo_err)
`endif
   );

   // 100 MHz free-running clock
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [23:0] q_of(input logic [23:0] i);
      return i ^ 24'h5A5A5A;
   endfunction

   // One clock of stimulus: samples the head mid-cycle, then updates the queue model
   task automatic drive(input logic push, input logic [23:0] i, input logic pull,
                        output Samp obs, output Samp exp, output logic popped);
      logic pull_ok;
      logic push_ok;
      Samp  s;
      PushIn       = push;
      SampI        = i;
      SampQ        = q_of(i);
      fifo_PullOut = pull;
      @(negedge Clk);
      obs     = fifo_samp;
      exp     = (sb.size() > 0) ? sb[0] : '0;
      pull_ok = pull && (sb.size() > 0);
      push_ok = push && ((sb.size() < DEPTH) || pull_ok);
      if ((push && !push_ok) || (pull && sb.size() == 0)) err_exp = 1'b1;
      popped = pull_ok;
      if (pull_ok) void'(sb.pop_front());
      if (push_ok) begin
         s.I = i;
         s.Q = q_of(i);
         sb.push_back(s);
      end
      @(posedge Clk);
      #1;
      PushIn       = 1'b0;
      fifo_PullOut = 1'b0;
   endtask

   task automatic test_reset();
      Samp  obs, exp;
      logic popped;
      Reset = 1'b0;
      #2;
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %b expected 1", fifo_empty); end
      checks++; if (fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", fifo_full); end
      checks++; if (fifo_samp !== 48'h0) begin errors++; $display("[TB] FAIL reset_samp: got %h expected 0", fifo_samp); end
      @(posedge Clk); #1;
      Reset = 1'b1;
      @(posedge Clk); #1;
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL release_flags: got empty=%b full=%b expected empty=1 full=0", fifo_empty, fifo_full); end
      drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
      checks++; if (obs !== 48'h0) begin errors++; $display("[TB] FAIL empty_pull_samp: got %h expected 0", obs); end
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL empty_pull_flags: got empty=%b full=%b expected empty=1 full=0", fifo_empty, fifo_full); end
`ifdef FIFO_ERR_EN
      checks++; if (fifo_err !== err_exp) begin errors++; $display("[TB] FAIL err_empty_pull: got %b expected %b", fifo_err, err_exp); end
`endif
   endtask

   task automatic test_single();
      Samp  obs, exp;
      logic popped;
      PushIn = 1'b1; SampI = 24'h000001; SampQ = 24'h7FFFFF;
      @(negedge Clk);
      checks++; if (fifo_samp !== 48'h0) begin errors++; $display("[TB] FAIL no_bypass: got %h expected 0", fifo_samp); end
      sb.push_back(Samp'{I: 24'sh000001, Q: 24'sh7FFFFF});
      @(posedge Clk); #1;
      PushIn = 1'b0;
      checks++; if (fifo_samp.I !== 24'h000001 || fifo_samp.Q !== 24'h7FFFFF) begin errors++; $display("[TB] FAIL single_head: got %h expected 0000017fffff", fifo_samp); end
      checks++; if (fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL single_not_empty: got %b expected 0", fifo_empty); end
      drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
      checks++; if (obs !== exp) begin errors++; $display("[TB] FAIL single_pop: got %h expected %h", obs, exp); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL single_empty_after: got %b expected 1", fifo_empty); end
   endtask

   task automatic test_full_drop();
      Samp  obs, exp;
      logic popped;
      for (int k = 1; k <= DEPTH; k++) drive(1'b1, 24'(k), 1'b0, obs, exp, popped);
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL full_after_8: got %b expected 1", fifo_full); end
      drive(1'b1, 24'd9, 1'b0, obs, exp, popped);
      checks++; if (fifo_full !== 1'b1 || fifo_samp.I !== 24'd1) begin errors++; $display("[TB] FAIL drop_9th: got full=%b head=%h expected full=1 head=000001", fifo_full, fifo_samp.I); end
`ifdef FIFO_ERR_EN
      checks++; if (fifo_err !== 1'b1) begin errors++; $display("[TB] FAIL err_drop: got %b expected 1", fifo_err); end
`endif
      for (int k = 1; k <= DEPTH; k++) begin
         drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
         checks++; if (obs !== exp || obs.I !== 24'(k)) begin errors++; $display("[TB] FAIL drain_order_%0d: got %h expected %h", k, obs, exp); end
      end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 1", fifo_empty); end
   endtask

   task automatic test_back_to_back();
      Samp  obs, exp;
      logic popped;
      for (int k = 1; k <= 4; k++) drive(1'b1, 24'(k), 1'b0, obs, exp, popped);
      for (int k = 5; k <= 24; k++) begin
         drive(1'b1, 24'(k), 1'b1, obs, exp, popped);
         checks++; if (obs !== exp || obs.I !== 24'(k - 4)) begin errors++; $display("[TB] FAIL stream_%0d: got %h expected %h", k, obs, exp); end
         checks++; if (fifo_empty !== 1'b0 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL stream_flags_%0d: got empty=%b full=%b expected 0 0", k, fifo_empty, fifo_full); end
      end
      for (int k = 21; k <= 24; k++) begin
         drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
         checks++; if (obs !== exp || obs.I !== 24'(k)) begin errors++; $display("[TB] FAIL stream_drain_%0d: got %h expected %h", k, obs, exp); end
      end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL stream_empty: got %b expected 1", fifo_empty); end
   endtask

   task automatic test_full_push_pull();
      Samp  obs, exp;
      logic popped;
      for (int k = 1; k <= DEPTH; k++) drive(1'b1, 24'(k), 1'b0, obs, exp, popped);
      drive(1'b1, 24'h100, 1'b1, obs, exp, popped);
      checks++; if (obs.I !== 24'd1) begin errors++; $display("[TB] FAIL full_pp_pop: got %h expected 000001", obs.I); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("[TB] FAIL full_pp_full: got %b expected 1", fifo_full); end
      for (int k = 0; k < DEPTH; k++) begin
         drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
         checks++; if (obs !== exp) begin errors++; $display("[TB] FAIL full_pp_drain_%0d: got %h expected %h", k, obs, exp); end
      end
      checks++; if (obs.I !== 24'h100) begin errors++; $display("[TB] FAIL full_pp_last: got %h expected 000100", obs.I); end
   endtask

   task automatic test_mid_reset();
      Samp  obs, exp;
      logic popped;
      for (int k = 1; k <= 5; k++) drive(1'b1, 24'(k + 32), 1'b0, obs, exp, popped);
      #2;
      Reset = 1'b0;
      #1;
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin errors++; $display("[TB] FAIL async_flags: got empty=%b full=%b expected 1 0", fifo_empty, fifo_full); end
      checks++; if (fifo_samp !== 48'h0) begin errors++; $display("[TB] FAIL async_samp: got %h expected 0", fifo_samp); end
`ifdef FIFO_ERR_EN
      checks++; if (fifo_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected 0", fifo_err); end
`endif
      sb.delete();
      err_exp = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      drive(1'b1, 24'h55, 1'b0, obs, exp, popped);
      checks++; if (fifo_samp.I !== 24'h55 || fifo_empty !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_head: got %h empty=%b expected 000055 empty=0", fifo_samp.I, fifo_empty); end
      drive(1'b0, 24'h0, 1'b1, obs, exp, popped);
      checks++; if (obs !== exp || fifo_empty !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_pop: got %h empty=%b expected %h empty=1", obs, fifo_empty, exp); end
   endtask

   // Run every scenario in order, then report
   initial begin
      checks       = 0;
      errors       = 0;
      err_exp      = 1'b0;
      Reset        = 1'b1;
      PushIn       = 1'b0;
      fifo_PullOut = 1'b0;
      SampI        = '0;
      SampQ        = '0;
      #1;
      test_reset();
      test_single();
      test_full_drop();
      test_back_to_back();
      test_full_push_pull();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
